// File: rtl/reg_write_arbiter_if.sv
// Register-file write port bundle: pipeline writeback, multicycle result
// channel and the arbitrated register-file write port.
interface reg_write_arbiter_if;
   logic        wb_valid_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic        wb_stall_o;
   logic        mc_valid_i;
   logic        mc_ready_o;
   logic [4:0]  mc_addr_i;
   logic [31:0] mc_data_i;
   logic        RegWrite_o;
   logic [4:0]  RDaddr_o;
   logic [31:0] RDdata_o;
   logic [31:0] pending_mask_o;

   modport master (
      output wb_valid_i, wb_addr_i, wb_data_i,
      output mc_valid_i, mc_addr_i, mc_data_i,
      input  wb_stall_o, mc_ready_o,
      input  RegWrite_o, RDaddr_o, RDdata_o, pending_mask_o
   );

   modport slave (
      input  wb_valid_i, wb_addr_i, wb_data_i,
      input  mc_valid_i, mc_addr_i, mc_data_i,
      output wb_stall_o, mc_ready_o,
      output RegWrite_o, RDaddr_o, RDdata_o, pending_mask_o
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and a queue of multicycle results, with starvation-forced draining.
module reg_write_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                clk_i,
   input logic                rst_i,
   reg_write_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [STV_W-1:0]   starve_q, starve_d;
   entry_t             mem_q [DEPTH];

   logic               mc_ready;
   logic               push;
   logic               pop;
   logic [PTR_W-1:0]   scan_idx;
   logic [31:0]        mask;

   // Ready is held low during reset so nothing is accepted into a clearing queue.
   assign mc_ready = ~rst_i & (count_q != CNT_W'(DEPTH));
   assign push     = bus.mc_valid_i & mc_ready & (bus.mc_addr_i != 5'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         count_q  <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         starve_q <= starve_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by count/head.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[tail_q] <= '{addr: bus.mc_addr_i, data: bus.mc_data_i};
      end
   end

   always_comb begin
      bus.RegWrite_o = 1'b0;
      bus.RDaddr_o   = bus.wb_addr_i;
      bus.RDdata_o   = bus.wb_data_i;
      bus.wb_stall_o = 1'b0;
      pop            = 1'b0;
      starve_d       = starve_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      state_d        = state_q;

      case (state_q)
         DRAIN: begin
            if (bus.wb_valid_i) begin
               bus.RegWrite_o = 1'b1;
               if (starve_q != STV_W'(STARVE_LIMIT)) begin
                  starve_d = starve_q + STV_W'(1);
               end
            end else begin
               bus.RegWrite_o = 1'b1;
               bus.RDaddr_o   = mem_q[head_q].addr;
               bus.RDdata_o   = mem_q[head_q].data;
               pop            = 1'b1;
            end
         end
         FORCE: begin
            bus.RegWrite_o = 1'b1;
            bus.RDaddr_o   = mem_q[head_q].addr;
            bus.RDdata_o   = mem_q[head_q].data;
            bus.wb_stall_o = bus.wb_valid_i;
            pop            = 1'b1;
         end
         default: begin
            bus.RegWrite_o = bus.wb_valid_i;
         end
      endcase

      if (pop) begin
         head_d   = head_q + PTR_W'(1);
         starve_d = '0;
      end
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // State follows the queue occupancy and starvation count of the next cycle.
      if (count_d == '0) begin
         state_d  = IDLE;
         starve_d = '0;
      end else if (starve_d == STV_W'(STARVE_LIMIT)) begin
         state_d = FORCE;
      end else begin
         state_d = DRAIN;
      end
   end

   always_comb begin
      mask     = '0;
      scan_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            mask[mem_q[scan_idx].addr] = 1'b1;
         end
      end
   end

   assign bus.mc_ready_o     = mc_ready;
   assign bus.pending_mask_o = mask;

endmodule
